// File: rtl/cmos_dvp_pkg.sv
// Shared definitions for the DVP test-pattern source: pattern selects,
// colour-bar palette and FSM state encoding.
package cmos_dvp_pkg;

   localparam logic [1:0] PAT_BARS  = 2'd0;
   localparam logic [1:0] PAT_COORD = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_SOLID = 2'd3;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cmos_pattern_pixel.sv
// Combinational test-pattern map: (pattern, x, y, solid) -> RGB565 pixel.
module cmos_pattern_pixel
   import cmos_dvp_pkg::*;
#(
   parameter int H_ACTIVE = 640
) (
   input  logic [1:0]  pattern,
   input  logic [15:0] x,
   input  logic [7:0]  y,
   input  logic [15:0] solid,
   output logic [15:0] pixel
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [15:0] bar_idx;

   always_comb begin
      bar_idx = x / 16'(BAR_W);
      pixel   = '0;
      case (pattern)
         PAT_BARS:  pixel = (bar_idx > 16'd7) ? bar_colour(3'd7) : bar_colour(bar_idx[2:0]);
         PAT_COORD: pixel = {y, x[7:0]};
         PAT_CHECK: pixel = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
         default:   pixel = solid;
      endcase
   end

endmodule

// File: rtl/cmos_dvp_pattern_gen.sv
// OV7670-style DVP source: VSYNC/HREF timing plus RGB565 test patterns.
// Optional per-frame byte checksum enabled by macro CMOS_PATGEN_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | outputs parked (VSYNC=1, HREF=0), waiting for iEnable
// ST_RUN  | h/v raster counters running, one frame at a time
module cmos_dvp_pattern_gen
   import cmos_dvp_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 144,
   parameter int VS_LINES = 3,
   parameter int V_BACK   = 17,
   parameter int V_FRONT  = 10
) (
   input  logic        CMOS_PCLK,
   input  logic        iRST_N,
   input  logic        iEnable,
   input  logic [1:0]  iPattern_sel,
   input  logic [15:0] iSolid,
   output logic        oCMOS_VSYNC,
   output logic        oCMOS_HREF,
   output logic [7:0]  oCMOS_DATA,
   output logic        oFrame_start,
   output logic [7:0]  oFrame_cnt,
   output logic [15:0] oFrame_sum
);

   localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT2 = HW'(2 * H_ACTIVE);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VS   = VW'(VS_LINES);
   localparam logic [VW-1:0] V_ACT0 = VW'(VS_LINES + V_BACK);
   localparam logic [VW-1:0] V_ACT1 = VW'(VS_LINES + V_BACK + V_ACTIVE);

   state_t        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [1:0]    pat_q, pat_d;
   logic [15:0]   solid_q, solid_d;
   logic          frame_end;
   logic          frame_first;
   logic          started_q;
   logic          href_c;
   logic [15:0]   x_c;
   logic [7:0]    y_c;
   logic [15:0]   pixel_c;

   always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_IDLE;
         h_q     <= '0;
         v_q     <= '0;
         pat_q   <= PAT_BARS;
         solid_q <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pat_q   <= pat_d;
         solid_q <= solid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      v_d       = v_q;
      pat_d     = pat_q;
      solid_d   = solid_q;
      frame_end = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iEnable) begin
               state_d = ST_RUN;
               h_d     = '0;
               v_d     = '0;
               pat_d   = iPattern_sel;
               solid_d = iSolid;
            end
         end
         ST_RUN: begin
            if (h_q == H_LAST) begin
               h_d = '0;
               if (v_q == V_LAST) begin
                  frame_end = 1'b1;
                  v_d       = '0;
                  // Pattern and enable only take effect on frame boundaries
                  if (iEnable) begin
                     pat_d   = iPattern_sel;
                     solid_d = iSolid;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  v_d = v_q + 1'b1;
               end
            end else begin
               h_d = h_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign frame_first = (state_q == ST_RUN) && (h_q == '0) && (v_q == '0);
   assign href_c      = (v_q >= V_ACT0) && (v_q < V_ACT1) && (h_q < H_ACT2);
   assign x_c         = 16'(h_q >> 1);
   assign y_c         = 8'(v_q - V_ACT0);

   cmos_pattern_pixel #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pixel (
      .pattern (pat_q),
      .x       (x_c),
      .y       (y_c),
      .solid   (solid_q),
      .pixel   (pixel_c)
   );

   always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oCMOS_VSYNC  <= 1'b1;
         oCMOS_HREF   <= 1'b0;
         oCMOS_DATA   <= '0;
         oFrame_start <= 1'b0;
         oFrame_cnt   <= '0;
         started_q    <= 1'b0;
      end else begin
         if (state_q == ST_RUN) begin
            oCMOS_VSYNC <= (v_q < V_VS);
            oCMOS_HREF  <= href_c;
            oCMOS_DATA  <= href_c ? (h_q[0] ? pixel_c[7:0] : pixel_c[15:8]) : 8'h00;
         end else begin
            oCMOS_VSYNC <= 1'b1;
            oCMOS_HREF  <= 1'b0;
            oCMOS_DATA  <= 8'h00;
         end
         // The very first frame after reset carries no start pulse
         oFrame_start <= frame_first & started_q;
         if (frame_first) started_q <= 1'b1;
         if (frame_end) oFrame_cnt <= oFrame_cnt + 8'd1;
      end
   end

`ifdef CMOS_PATGEN_CHECKSUM_EN
   logic [15:0] sum_acc_q;

   always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sum_acc_q  <= '0;
         oFrame_sum <= '0;
      end else begin
         if (frame_first) sum_acc_q <= '0;
         else if (oCMOS_HREF) sum_acc_q <= sum_acc_q + {8'h00, oCMOS_DATA};
         if (frame_end) oFrame_sum <= sum_acc_q;
      end
   end
`else
   assign oFrame_sum = '0;
`endif

endmodule

// File: tb/tb_cmos_dvp_pattern_gen.sv
// Randomized directed bench for cmos_dvp_pattern_gen with a frame-level reference model.
module tb_cmos_dvp_pattern_gen;

   localparam int H_ACTIVE = 8;
   localparam int V_ACTIVE = 4;
   localparam int H_BLANK  = 4;
   localparam int VS_LINES = 2;
   localparam int V_BACK   = 1;
   localparam int V_FRONT  = 1;
   localparam int H_TOTAL  = 2 * H_ACTIVE + H_BLANK;
   localparam int V_TOTAL  = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int ACT0     = VS_LINES + V_BACK;

   logic        CMOS_PCLK = 1'b0;
   logic        iRST_N;
   logic        iEnable;
   logic [1:0]  iPattern_sel;
   logic [15:0] iSolid;
   logic        oCMOS_VSYNC;
   logic        oCMOS_HREF;
   logic [7:0]  oCMOS_DATA;
   logic        oFrame_start;
   logic [7:0]  oFrame_cnt;
   logic [15:0] oFrame_sum;

   int          checks = 0;
   int          errors = 0;
   int          fs_pulses = 0;
   logic [7:0]  exp_cnt = 8'd0;

   always #5 CMOS_PCLK = ~CMOS_PCLK;

   cmos_dvp_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .H_BLANK  (H_BLANK),
      .VS_LINES (VS_LINES),
      .V_BACK   (V_BACK),
      .V_FRONT  (V_FRONT)
   ) dut (
      .CMOS_PCLK    (CMOS_PCLK),
      .iRST_N       (iRST_N),
      .iEnable      (iEnable),
      .iPattern_sel (iPattern_sel),
      .iSolid       (iSolid),
      .oCMOS_VSYNC  (oCMOS_VSYNC),
      .oCMOS_HREF   (oCMOS_HREF),
      .oCMOS_DATA   (oCMOS_DATA),
      .oFrame_start (oFrame_start),
      .oFrame_cnt   (oFrame_cnt),
      .oFrame_sum   (oFrame_sum)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_pixel(input int pat, input int x, input int y,
                                             input logic [15:0] sol);
      logic [15:0] bars [8];
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      case (pat)
         0:       return bars[(x / (H_ACTIVE / 8)) % 8];
         1:       return {8'(y % 256), 8'(x % 256)};
         2:       return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
         default: return sol;
      endcase
   endfunction

   task automatic check_reset_values(input string where);
      chk({where, "_vsync"}, oCMOS_VSYNC, 1);
      chk({where, "_href"},  oCMOS_HREF, 0);
      chk({where, "_data"},  oCMOS_DATA, 0);
      chk({where, "_fstart"}, oFrame_start, 0);
      chk({where, "_cnt"},   oFrame_cnt, 0);
      chk({where, "_sum"},   oFrame_sum, 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CMOS_PCLK);
         chk("idle_vsync", oCMOS_VSYNC, 1);
         chk("idle_href", oCMOS_HREF, 0);
         chk("idle_data", oCMOS_DATA, 0);
         chk("idle_fstart", oFrame_start, 0);
         chk("idle_cnt", oFrame_cnt, exp_cnt);
      end
   endtask

   // Checks one frame of output, cycle by cycle, starting at its first output cycle.
   // At cycle chg_k the next-frame inputs are applied; the frame stops early after stop_k.
   task automatic run_frame(input logic [1:0] pat, input logic [15:0] sol, input bit first,
                            input int chg_k, input logic [1:0] npat, input logic [15:0] nsol,
                            input logic nen, input int stop_k);
      logic [15:0] sum;
      logic [15:0] pix;
      logic [7:0]  b;
      int          v, h;
      bit          vs, act;
      sum = 16'h0;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge CMOS_PCLK);
         v   = k / H_TOTAL;
         h   = k % H_TOTAL;
         vs  = (v < VS_LINES);
         act = (v >= ACT0) && (v < ACT0 + V_ACTIVE) && (h < 2 * H_ACTIVE);
         b   = 8'h00;
         if (act) begin
            pix = ref_pixel(int'(pat), h / 2, v - ACT0, sol);
            b   = (h % 2 == 0) ? pix[15:8] : pix[7:0];
            sum = sum + 16'(b);
         end
         chk("vsync", oCMOS_VSYNC, vs);
         chk("href", oCMOS_HREF, act);
         chk("data", oCMOS_DATA, b);
         chk("frame_start", oFrame_start, (k == 0) && !first);
         if (oFrame_start === 1'b1) fs_pulses++;
         if (k == FRAME - 2) chk("cnt_hold", oFrame_cnt, exp_cnt);
         if (k == FRAME - 1) begin
            exp_cnt = exp_cnt + 8'd1;
            chk("cnt_inc", oFrame_cnt, exp_cnt);
`ifdef CMOS_PATGEN_CHECKSUM_EN
            chk("frame_sum", oFrame_sum, sum);
`else
            chk("frame_sum", oFrame_sum, 0);
`endif
         end
         if (k == chg_k) begin
            iPattern_sel = npat;
            iSolid       = nsol;
            iEnable      = nen;
         end
         if (k == stop_k) break;
      end
   endtask

   initial begin
      logic [1:0]  cur_pat, nxt_pat;
      logic [15:0] cur_sol, nxt_sol;
      int          chg;

      iRST_N       = 1'b0;
      iEnable      = 1'b1;
      iPattern_sel = 2'd3;
      iSolid       = 16'h1234;
      repeat (3) @(negedge CMOS_PCLK);
      check_reset_values("rst");
      iRST_N = 1'b1;
      idle_cycles(1);

      // Solid 1234 frame, then coordinate pattern
      nxt_sol = 16'($urandom);
      run_frame(2'd3, 16'h1234, 1'b1, 100, 2'd1, nxt_sol, 1'b1, -1);
      run_frame(2'd1, nxt_sol, 1'b0, 30, 2'd0, 16'($urandom), 1'b1, -1);
      // Colour bars, with a mid-frame switch to checker
      cur_sol = 16'($urandom);
      run_frame(2'd0, 16'h0000, 1'b0, 80, 2'd2, cur_sol, 1'b1, -1);
      // Checker frame; enable drops on line 3 but the frame must complete
      run_frame(2'd2, cur_sol, 1'b0, 3 * H_TOTAL, 2'($urandom), 16'($urandom), 1'b0, -1);
      idle_cycles(10);
      cur_sol      = 16'($urandom);
      iEnable      = 1'b1;
      iPattern_sel = 2'd3;
      iSolid       = cur_sol;
      idle_cycles(1);
      nxt_sol = 16'($urandom);
      run_frame(2'd3, cur_sol, 1'b0, 50, 2'd1, nxt_sol, 1'b1, -1);

      // Asynchronous reset in the middle of an active line
      run_frame(2'd1, nxt_sol, 1'b0, -1, 2'd1, nxt_sol, 1'b1, 3 * H_TOTAL + 10);
      #2 iRST_N = 1'b0;
      #1 check_reset_values("async_rst");
      exp_cnt = 8'd0;
      repeat (2) @(negedge CMOS_PCLK);
      cur_pat      = 2'($urandom);
      cur_sol      = 16'($urandom);
      iPattern_sel = cur_pat;
      iSolid       = cur_sol;
      iEnable      = 1'b1;
      iRST_N       = 1'b1;
      idle_cycles(1);

      // 256 back-to-back frames with random pattern changes between them
      fs_pulses = 0;
      for (int f = 0; f < 256; f++) begin
         nxt_pat = 2'($urandom);
         nxt_sol = 16'($urandom);
         chg     = $urandom_range(FRAME - 2, 0);
         run_frame(cur_pat, cur_sol, (f == 0), chg, nxt_pat, nxt_sol, 1'b1, -1);
         cur_pat = nxt_pat;
         cur_sol = nxt_sol;
      end
      chk("cnt_wrap", oFrame_cnt, 8'h00);
      chk("fstart_count", fs_pulses, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmos_dvp_pattern_gen.md
Name: cmos_dvp_pattern_gen

Overview:
Synthesizable DVP sensor-side source. It emulates the OV7670 output interface and produces VSYNC, HREF and 8-bit RGB565 byte pairs in the CMOS_PCLK domain. It feeds the capture path in place of a real sensor, for board bring-up and regression. Frames carry selectable test patterns, so downstream SDRAM/VGA paths can be checked pixel-exactly.

Parameters:
H_ACTIVE, 640, active pixels per line (2 bytes each).
V_ACTIVE, 480, active lines per frame.
H_BLANK, 144, PCLK cycles of HREF-low per line.
VS_LINES, 3, lines with VSYNC high at frame start.
V_BACK, 17, VSYNC-low lines before first active line.
V_FRONT, 10, VSYNC-low lines after last active line.

Ports:
CMOS_PCLK  in  1  pixel-byte clock
iRST_N  in  1  reset
iEnable  in  1  run request, sampled at frame boundary
iPattern_sel  in  2  0 colour bars, 1 coordinate, 2 checker, 3 solid
iSolid  in  16  RGB565 value for pattern 3
oCMOS_VSYNC  out  1  high = vertical blank, low = frame valid
oCMOS_HREF  out  1  high = active byte
oCMOS_DATA  out  8  byte data
oFrame_start  out  1  one-cycle pulse on VSYNC rise
oFrame_cnt  out  8  completed frames, wraps 255->0
oFrame_sum  out  16  per-frame byte checksum (optional feature)

Behaviour:
- Reset iRST_N, asynchronous, active-low; clock CMOS_PCLK.
- Reset values: oCMOS_VSYNC=1, oCMOS_HREF=0, oCMOS_DATA=0, oFrame_start=0, oFrame_cnt=0, oFrame_sum=0. FSM=IDLE, h=0, v=0.
- Line timing: H_TOTAL=2*H_ACTIVE+H_BLANK. Frame timing: V_TOTAL=VS_LINES+V_BACK+V_ACTIVE+V_FRONT.
- FSM IDLE:
  - Outputs idle (VSYNC=1, HREF=0, DATA=0).
  - If iEnable=1: latch iPattern_sel and iSolid, go RUN with h=0, v=0.
- FSM RUN:
  - h counts 0..H_TOTAL-1, then wraps and increments v.
  - At h=H_TOTAL-1 and v=V_TOTAL-1 (frame end): if iEnable=1, relatch pattern/solid and restart at 0,0; else go IDLE.
  - iEnable deassert mid-frame never truncates a frame.
  - Pattern changes mid-frame are ignored until the next frame boundary.
- Outputs are registered, with 1-cycle latency from counter state (h,v):
  - VSYNC = (v<VS_LINES).
  - HREF = (v in [VS_LINES+V_BACK, VS_LINES+V_BACK+V_ACTIVE)) && (h<2*H_ACTIVE).
  - x=h>>1; y=v-(VS_LINES+V_BACK).
  - Even h drives pixel[15:8]; odd h drives pixel[7:0]. DATA=0 when HREF=0.
- Patterns:
  - Pattern 0: 8 bars, each H_ACTIVE/8 wide, index=x/(H_ACTIVE/8). Colours: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Pattern 1: pixel={y[7:0], x[7:0]}.
  - Pattern 2: pixel=(x[5]^y[5]) ? FFFF : 0000.
  - Pattern 3: pixel=latched iSolid.
- oFrame_start is a 1-cycle pulse on the output cycle where VSYNC goes 0->1 or first asserts leaving IDLE. It is not pulsed on the first frame after reset.
- oFrame_cnt increments on the frame-end cycle of every completed frame, registered and visible 1 cycle later. It wraps at 8 bits.
- Reset mid-frame: immediate return to reset values; no partial-frame count.

Optional Feature:
- Macro CMOS_PATGEN_CHECKSUM_EN.
- Defined: 16-bit accumulator sums every byte emitted with HREF=1, modulo 2^16.
  - Latched to oFrame_sum on the frame-end cycle.
  - Accumulator cleared at frame start.
- Undefined: oFrame_sum tied to 0 and no accumulator logic is generated.

Decomposition:
- Shared package cmos_dvp_pkg holds:
  - Pattern select localparams (PAT_BARS=0, PAT_COORD=1, PAT_CHECK=2, PAT_SOLID=3).
  - The 8 bar colour constants.
  - FSM state encoding (IDLE, RUN).
- Sub-module cmos_pattern_pixel: combinational map (pattern, x, y, solid) -> 16-bit pixel. It is reused by the verification scoreboard.

Test Plan:
Bench parameters are H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VS_LINES=2, V_BACK=1, V_FRONT=1, giving H_TOTAL=20 and V_TOTAL=8.
- Reset, iEnable=1, pattern 3, iSolid=1234:
  - VSYNC high for 40 cycles.
  - HREF high in 4 bursts of 16 cycles.
  - Bytes alternate 12,34.
  - oFrame_cnt=1 after 160 cycles; oFrame_sum=08C0 (with macro).
- Pattern 1: on line y=2, pixel x=5 -> bytes 02,05. Every HREF cycle matches the cmos_pattern_pixel model.
- Pattern 0: each bar is 1 pixel wide. Byte sequence FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 on every line.
- Deassert iEnable mid-frame at v=3:
  - The frame completes.
  - Outputs go idle: VSYNC=1, HREF=0, no oFrame_start.
  - oFrame_cnt is incremented once.
- Change iPattern_sel mid-frame: the current frame is unchanged, and the next frame uses the new pattern. Assert iRST_N low mid-line: outputs return to reset values asynchronously.
- Run 256 frames -> oFrame_cnt wraps to 0. oFrame_start pulses exactly once per frame after the first.
